// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control-bit layout and per-boundary payload widths.
// Also the skid-buffer occupancy encoding used by pipe_stage_reg.
package pipe_pkg;

  localparam int CTRL_W        = 4;

  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;

  // PC + Inst
  localparam int DATA_W_IF_ID  = 64;
  // PC + RD1 + RD2 + Imm + Inst
  localparam int DATA_W_ID_EX  = 160;
  // ALUout + RD2 + RD + Inst
  localparam int DATA_W_EX_MEM = 101;
  // ALUout + MemData + RD
  localparam int DATA_W_MEM_WB = 69;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } skid_st_e;

  function automatic logic xfer(
    input logic v,
    input logic r
  );
    return v & r;
  endfunction

  function automatic logic ctrl_writes(
    input logic [CTRL_W-1:0] c
  );
    return c[CTRL_REGWRITE] | c[CTRL_MEMWRITE];
  endfunction

  function automatic logic ctrl_mem(
    input logic [CTRL_W-1:0] c
  );
    return c[CTRL_MEMREAD] | c[CTRL_MEMWRITE]
         | c[CTRL_MEMTOREG];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, bubble ctrl masking, optional skid.
// PIPE_STAGE_PERF_CNT_EN adds saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_reg #(
  parameter int DATA_W = pipe_pkg::DATA_W_EX_MEM,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int SKID   = 0,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  import pipe_pkg::*;

  logic              w_in_ready;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_data;
  logic [CTRL_W-1:0] w_ctrl;

  if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_reg: widths must be positive");
  end

  if (SKID == 0) begin : g_single

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_ready = !r_valid | out_ready;
    assign w_in_xfer  = xfer(in_valid, w_in_ready);
    assign w_out_xfer = xfer(r_valid, out_ready);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_ctrl  <= '0;
      end else if (flush) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else if (w_in_xfer) begin
        r_valid <= 1'b1;
        r_data  <= in_data;
        r_ctrl  <= in_ctrl;
      end else if (w_out_xfer) begin
        r_valid <= 1'b0;
      end
    end

    assign w_out_valid = r_valid;
    assign w_data      = r_data;
    assign w_ctrl      = r_ctrl;

  end else begin : g_skid

    skid_st_e          r_state;
    skid_st_e          w_state_n;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_m_data;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic [DATA_W-1:0] r_s_data;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_ld_main_in;
    logic              w_ld_main_skid;
    logic              w_ld_skid;

    assign w_in_ready  = r_in_ready;
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_xfer   = xfer(in_valid, r_in_ready);
    assign w_out_xfer  = xfer(w_out_valid, out_ready);

    always_comb begin
      w_state_n      = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_ld_main_in = 1'b1;
            w_state_n    = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (w_in_xfer && w_out_xfer) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_ld_skid = 1'b1;
            w_state_n = ST_FULL;
          end else if (w_out_xfer) begin
            w_state_n = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_ld_main_skid = 1'b1;
            w_state_n      = ST_MAIN;
          end
        end
        default: begin
          w_state_n = ST_EMPTY;
        end
      endcase
      if (flush) begin
        w_state_n = ST_EMPTY;
      end
    end

    // in_ready is the registered "skid will be empty" flag
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state    <= ST_EMPTY;
        r_in_ready <= 1'b1;
        r_m_data   <= '0;
        r_m_ctrl   <= '0;
        r_s_data   <= '0;
        r_s_ctrl   <= '0;
      end else begin
        r_state    <= w_state_n;
        r_in_ready <= (w_state_n != ST_FULL);
        if (flush) begin
          r_m_ctrl <= '0;
          r_s_ctrl <= '0;
        end else begin
          if (w_ld_main_in) begin
            r_m_data <= in_data;
            r_m_ctrl <= in_ctrl;
          end else if (w_ld_main_skid) begin
            r_m_data <= r_s_data;
            r_m_ctrl <= r_s_ctrl;
          end
          if (w_ld_skid) begin
            r_s_data <= in_data;
            r_s_ctrl <= in_ctrl;
          end
        end
      end
    end

    assign w_data = r_m_data;
    assign w_ctrl = r_m_ctrl;

  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_data;
  assign out_ctrl  = w_out_valid ? w_ctrl : '0;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic w_stall;
  logic w_bubble;

  assign w_stall  = w_out_valid & !out_ready;
  assign w_bubble = !w_out_valid;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .i_clear (rst),
    .i_inc   (w_stall),
    .o_cnt   (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk     (clk),
    .i_clear (rst),
    .i_inc   (w_bubble),
    .o_cnt   (bubble_cnt)
  );
`endif

endmodule
